// File: rtl/frame_end_alert_nch_pkg.sv
// Shared types and helpers for the N-channel frame-end alert block.
// Optional per-channel frame counting is enabled by the FEA_FRAME_CNT_EN macro.
package fea_pkg;

    typedef enum logic {
        FEA_IDLE = 1'b0,
        FEA_OPEN = 1'b1
    } fea_state_t;

    localparam int unsigned FEA_CNT_W = 16;

    // True when a timeout limit fits in a counter of the given width.
    function automatic bit to_limit_ok(input longint unsigned limit, input int unsigned w);
        return (w >= 32'd64) || (limit < (64'd1 << w));
    endfunction

endpackage

// File: rtl/frame_end_alert_nch_if.sv
// Marker-strobe and alert bundle between the marker decoders and the frame-end alert block.
// Carries cnt_clr/frame_cnt only when FEA_FRAME_CNT_EN is defined.
interface frame_end_alert_nch_if
    import fea_pkg::*;
#(
    parameter int unsigned N_CH = 5
);
    logic [N_CH-1:0] ch_en;
    logic [N_CH-1:0] me_ctrls;
    logic [N_CH-1:0] me_crc;
    logic [N_CH-1:0] fe;
    logic [N_CH-1:0] to_err;
    logic [N_CH-1:0] ovr_err;
    logic [N_CH-1:0] orphan_crc;
    logic [N_CH-1:0] busy;
`ifdef FEA_FRAME_CNT_EN
    logic                      cnt_clr;
    logic [N_CH*FEA_CNT_W-1:0] frame_cnt;
`endif

`ifdef FEA_FRAME_CNT_EN
    modport master (
        output ch_en, me_ctrls, me_crc, cnt_clr,
        input  fe, to_err, ovr_err, orphan_crc, busy, frame_cnt
    );
    modport slave (
        input  ch_en, me_ctrls, me_crc, cnt_clr,
        output fe, to_err, ovr_err, orphan_crc, busy, frame_cnt
    );
`else
    modport master (
        output ch_en, me_ctrls, me_crc,
        input  fe, to_err, ovr_err, orphan_crc, busy
    );
    modport slave (
        input  ch_en, me_ctrls, me_crc,
        output fe, to_err, ovr_err, orphan_crc, busy
    );
`endif

endinterface

// File: rtl/frame_end_alert_nch_channel.sv
// One channel: IDLE/OPEN frame tracker with open-frame timeout and registered alert pulses.
// With FEA_FRAME_CNT_EN defined it also keeps a saturating count of frame-end pulses.
module fea_channel
    import fea_pkg::*;
#(
    parameter int unsigned TO_W     = 16,
    parameter int unsigned TO_LIMIT = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef FEA_FRAME_CNT_EN
    input  logic                 cnt_clr,
    output logic [FEA_CNT_W-1:0] frame_cnt,
`endif
    input  logic                 en,
    input  logic                 ctrl,
    input  logic                 crc,
    output logic                 fe,
    output logic                 to_err,
    output logic                 ovr_err,
    output logic                 orphan_crc,
    output logic                 busy
);

    localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};
    localparam bit              TO_ON   = (TO_LIMIT != 32'd0);
    // The counter holds (cycles open - 1), so expiry is one below the limit.
    localparam logic [TO_W-1:0] TO_LAST = TO_ON ? TO_W'(TO_LIMIT - 32'd1) : {TO_W{1'b0}};

    fea_state_t      state_r, state_s;
    logic [TO_W-1:0] cnt_r, cnt_s;
    logic            fe_r, fe_s;
    logic            to_r, to_s;
    logic            ovr_r, ovr_s;
    logic            orph_r, orph_s;

    // Next-state, timeout counter and pulse decode for one channel.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        fe_s    = 1'b0;
        to_s    = 1'b0;
        ovr_s   = 1'b0;
        orph_s  = 1'b0;
        if (!en) begin
            state_s = FEA_IDLE;
            cnt_s   = {TO_W{1'b0}};
        end else begin
            case (state_r)
                FEA_IDLE: begin
                    cnt_s = {TO_W{1'b0}};
                    if (ctrl && !crc) begin
                        state_s = FEA_OPEN;
                    end else if (ctrl && crc) begin
                        fe_s = 1'b1;
                    end else if (crc) begin
                        orph_s = 1'b1;
                    end else begin
                        state_s = FEA_IDLE;
                    end
                end
                FEA_OPEN: begin
                    if (crc) begin
                        fe_s    = 1'b1;
                        cnt_s   = {TO_W{1'b0}};
                        state_s = ctrl ? FEA_OPEN : FEA_IDLE;
                    end else if (ctrl) begin
                        ovr_s = 1'b1;
                        cnt_s = {TO_W{1'b0}};
                    end else if (TO_ON && (cnt_r == TO_LAST)) begin
                        to_s    = 1'b1;
                        cnt_s   = {TO_W{1'b0}};
                        state_s = FEA_IDLE;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + TO_W'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    state_s = FEA_IDLE;
                    cnt_s   = {TO_W{1'b0}};
                end
            endcase
        end
    end

    // State, counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FEA_IDLE;
            cnt_r   <= {TO_W{1'b0}};
            fe_r    <= 1'b0;
            to_r    <= 1'b0;
            ovr_r   <= 1'b0;
            orph_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            fe_r    <= fe_s;
            to_r    <= to_s;
            ovr_r   <= ovr_s;
            orph_r  <= orph_s;
        end
    end

    assign fe         = fe_r;
    assign to_err     = to_r;
    assign ovr_err    = ovr_r;
    assign orphan_crc = orph_r;
    assign busy       = (state_r == FEA_OPEN);

`ifdef FEA_FRAME_CNT_EN
    localparam logic [FEA_CNT_W-1:0] FCNT_MAX = {FEA_CNT_W{1'b1}};

    logic [FEA_CNT_W-1:0] fcnt_r, fcnt_s;

    // Frame count: clear wins over an increment in the same cycle.
    always_comb begin
        fcnt_s = fcnt_r;
        if (cnt_clr) begin
            fcnt_s = {FEA_CNT_W{1'b0}};
        end else if (fe_s && (fcnt_r != FCNT_MAX)) begin
            fcnt_s = fcnt_r + FEA_CNT_W'(1);
        end else begin
            fcnt_s = fcnt_r;
        end
    end

    // Frame count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_r <= {FEA_CNT_W{1'b0}};
        end else begin
            fcnt_r <= fcnt_s;
        end
    end

    assign frame_cnt = fcnt_r;
`endif

endmodule

// File: rtl/frame_end_alert_nch.sv
// N-channel frame-end alert: one independent fea_channel per marker channel.
// Define FEA_FRAME_CNT_EN to add per-channel frame counters and a shared clear.
module frame_end_alert_nch
    import fea_pkg::*;
#(
    parameter int unsigned N_CH     = 5,
    parameter int unsigned TO_W     = 16,
    parameter int unsigned TO_LIMIT = 1000
) (
    input logic                  clk,
    input logic                  rst_n,
    frame_end_alert_nch_if.slave bus
);

    if (!to_limit_ok(64'(TO_LIMIT), TO_W)) begin : g_bad_to_limit
        $error("frame_end_alert_nch: TO_LIMIT must be below 2**TO_W");
    end
    if ((N_CH < 32'd1) || (N_CH > 32'd32)) begin : g_bad_n_ch
        $error("frame_end_alert_nch: N_CH must be 1..32");
    end

    logic [N_CH-1:0] fe_s;
    logic [N_CH-1:0] to_err_s;
    logic [N_CH-1:0] ovr_err_s;
    logic [N_CH-1:0] orphan_crc_s;
    logic [N_CH-1:0] busy_s;
`ifdef FEA_FRAME_CNT_EN
    logic [N_CH*FEA_CNT_W-1:0] frame_cnt_s;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        fea_channel #(
            .TO_W     (TO_W),
            .TO_LIMIT (TO_LIMIT)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
`ifdef FEA_FRAME_CNT_EN
            .cnt_clr    (bus.cnt_clr),
            .frame_cnt  (frame_cnt_s[i*FEA_CNT_W +: FEA_CNT_W]),
`endif
            .en         (bus.ch_en[i]),
            .ctrl       (bus.me_ctrls[i]),
            .crc        (bus.me_crc[i]),
            .fe         (fe_s[i]),
            .to_err     (to_err_s[i]),
            .ovr_err    (ovr_err_s[i]),
            .orphan_crc (orphan_crc_s[i]),
            .busy       (busy_s[i])
        );
    end

    assign bus.fe         = fe_s;
    assign bus.to_err     = to_err_s;
    assign bus.ovr_err    = ovr_err_s;
    assign bus.orphan_crc = orphan_crc_s;
    assign bus.busy       = busy_s;
`ifdef FEA_FRAME_CNT_EN
    assign bus.frame_cnt  = frame_cnt_s;
`endif

endmodule

// File: tb/tb_frame_end_alert_nch.sv
// Bench for frame_end_alert_nch: two instances (long and short timeout) driven identically,
// checked every cycle against a frame-level model plus literal scenario expectations.
module tb_frame_end_alert_nch;
    import fea_pkg::*;

    localparam int N     = 5;
    localparam int LIM_A = 1000;
    localparam int LIM_B = 8;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    frame_end_alert_nch_if #(.N_CH(N)) bus_a ();
    frame_end_alert_nch_if #(.N_CH(N)) bus_b ();

    frame_end_alert_nch #(.N_CH(N), .TO_W(16), .TO_LIMIT(LIM_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    frame_end_alert_nch #(.N_CH(N), .TO_W(4), .TO_LIMIT(LIM_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] en, input logic [N-1:0] ctrl,
                         input logic [N-1:0] crc, input logic clr);
        bus_a.ch_en = en; bus_a.me_ctrls = ctrl; bus_a.me_crc = crc;
        bus_b.ch_en = en; bus_b.me_ctrls = ctrl; bus_b.me_crc = crc;
`ifdef FEA_FRAME_CNT_EN
        bus_a.cnt_clr = clr; bus_b.cnt_clr = clr;
`else
        if (clr) begin end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame-level model: open flag, cycles-open age, fe count per channel and per instance.
    bit             m_open [2][N];
    int             m_age  [2][N];
    int             m_cnt  [2][N];
    logic [N-1:0]   e_fe[2], e_to[2], e_ovr[2], e_orph[2];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < 2; d++) begin
                int lim;
                lim = (d == 0) ? LIM_A : LIM_B;
                e_fe[d] = '0; e_to[d] = '0; e_ovr[d] = '0; e_orph[d] = '0;
                for (int i = 0; i < N; i++) begin
                    logic en, c, r, clr;
                    en = bus_a.ch_en[i]; c = bus_a.me_ctrls[i]; r = bus_a.me_crc[i];
`ifdef FEA_FRAME_CNT_EN
                    clr = bus_a.cnt_clr;
`else
                    clr = 1'b0;
`endif
                    if (!rst_n) begin
                        m_open[d][i] = 0; m_age[d][i] = 0; m_cnt[d][i] = 0;
                    end else begin
                        if (!en) begin
                            m_open[d][i] = 0;
                        end else if (!m_open[d][i]) begin
                            if (c && r) e_fe[d][i] = 1'b1;
                            else if (c) begin m_open[d][i] = 1; m_age[d][i] = 1; end
                            else if (r) e_orph[d][i] = 1'b1;
                        end else begin
                            if (r) begin
                                e_fe[d][i] = 1'b1;
                                if (c) m_age[d][i] = 1; else m_open[d][i] = 0;
                            end else if (c) begin
                                e_ovr[d][i] = 1'b1; m_age[d][i] = 1;
                            end else if (m_age[d][i] == lim) begin
                                e_to[d][i] = 1'b1; m_open[d][i] = 0;
                            end else begin
                                m_age[d][i]++;
                            end
                        end
                        if (clr) m_cnt[d][i] = 0;
                        else if (e_fe[d][i] && m_cnt[d][i] < 65535) m_cnt[d][i]++;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [N-1:0] a_fe, a_to, a_ovr, a_orph, a_busy, ebusy;
                a_fe   = (d == 0) ? bus_a.fe         : bus_b.fe;
                a_to   = (d == 0) ? bus_a.to_err     : bus_b.to_err;
                a_ovr  = (d == 0) ? bus_a.ovr_err    : bus_b.ovr_err;
                a_orph = (d == 0) ? bus_a.orphan_crc : bus_b.orphan_crc;
                a_busy = (d == 0) ? bus_a.busy       : bus_b.busy;
                for (int i = 0; i < N; i++) ebusy[i] = m_open[d][i];
                check($sformatf("model_fe[%0d]", d),   32'(a_fe),   32'(e_fe[d]));
                check($sformatf("model_to[%0d]", d),   32'(a_to),   32'(e_to[d]));
                check($sformatf("model_ovr[%0d]", d),  32'(a_ovr),  32'(e_ovr[d]));
                check($sformatf("model_orph[%0d]", d), 32'(a_orph), 32'(e_orph[d]));
                check($sformatf("model_busy[%0d]", d), 32'(a_busy), 32'(ebusy));
`ifdef FEA_FRAME_CNT_EN
                for (int i = 0; i < N; i++) begin
                    logic [15:0] fc;
                    fc = (d == 0) ? bus_a.frame_cnt[i*16 +: 16] : bus_b.frame_cnt[i*16 +: 16];
                    check($sformatf("model_cnt[%0d][%0d]", d, i), 32'(fc), 32'(m_cnt[d][i]));
                end
`endif
            end
        end
    end

    initial begin
        logic [N-1:0] ctrl, crc, en;
        logic [N-1:0] ef, eo, ev, et, eb;
        int c;

        rst_n = 1'b0;
        drive('0, '0, '0, 1'b0);
        step(); step();
        check("reset_busy_a", 32'(bus_a.busy), 32'd0);
        check("reset_fe_a",   32'(bus_a.fe),   32'd0);
        step();
        rst_n = 1'b1;

        // Scenario timeline: strobes at cycle t appear as outputs in cycle t+1.
        for (int t = 0; t <= 25; t++) begin
            ctrl = '0; crc = '0;
            if (t == 10) ctrl[0] = 1'b1;
            if (t == 20) crc[0]  = 1'b1;
            if (t == 3 || t == 8) ctrl[1] = 1'b1;
            if (t == 12) crc[1] = 1'b1;
            if (t == 5)  crc[2] = 1'b1;
            if (t == 0)  ctrl[3] = 1'b1;
            if (t == 15) crc[3] = 1'b1;
            if (t == 0)  ctrl[4] = 1'b1;
            if (t == 6)  crc[4] = 1'b1;
            en = (t >= 4) ? 5'b01111 : 5'b11111;
            drive(en, ctrl, crc, 1'b0);
            step();
            c = t + 1;
            ef = '0; eo = '0; ev = '0; et = '0; eb = '0;
            ef[0] = (c == 21);            eb[0] = (c >= 11 && c <= 20);
            ef[1] = (c == 13); ev[1] = (c == 9); eb[1] = (c >= 4 && c <= 12);
            eo[2] = (c == 6);
            ef[3] = (c == 16);            eb[3] = (c >= 1 && c <= 15);
            eb[4] = (c >= 1 && c <= 4);
            check("plan_fe_a",   32'(bus_a.fe),         32'(ef));
            check("plan_orph_a", 32'(bus_a.orphan_crc), 32'(eo));
            check("plan_ovr_a",  32'(bus_a.ovr_err),    32'(ev));
            check("plan_to_a",   32'(bus_a.to_err),     32'(et));
            check("plan_busy_a", 32'(bus_a.busy),       32'(eb));
            // Short-timeout instance: channel 3 times out at cycle 9, later crc is orphan.
            check("plan_to_b3",   32'(bus_b.to_err[3]),     32'(c == 9));
            check("plan_busy_b3", 32'(bus_b.busy[3]),       32'(c >= 1 && c <= 8));
            check("plan_orph_b3", 32'(bus_b.orphan_crc[3]), 32'(c == 16));
            check("plan_fe_b3",   32'(bus_b.fe[3]),         32'd0);
        end

        // Open every channel, then assert reset mid-frame.
        drive('1, '1, '0, 1'b0);
        step();
        drive('1, '0, '0, 1'b0);
        for (int t = 1; t < 7; t++) step();
        check("open_all_busy_a", 32'(bus_a.busy), 32'h1f);
        check("open_all_busy_b", 32'(bus_b.busy), 32'h1f);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy_a", 32'(bus_a.busy), 32'd0);
        check("rst_mid_busy_b", 32'(bus_b.busy), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

`ifdef FEA_FRAME_CNT_EN
        for (int k = 0; k < 3; k++) begin
            drive('1, 5'b00001, '0, 1'b0); step();
            drive('1, '0, 5'b00001, 1'b0); step();
        end
        drive('1, '0, '0, 1'b0); step();
        check("cnt_three_frames", 32'(bus_a.frame_cnt[15:0]), 32'd3);
        drive('1, 5'b00001, '0, 1'b0); step();
        drive('1, '0, 5'b00001, 1'b1); step();
        check("cnt_clr_with_fe_fe", 32'(bus_a.fe[0]), 32'd1);
        check("cnt_clr_with_fe",    32'(bus_a.frame_cnt[15:0]), 32'd0);
        drive('1, '0, '0, 1'b0); step();
`endif

        // Randomized traffic with alternating strobe density and occasional resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int p;
            p = ((cyc / 400) % 2 == 1) ? 4 : 20;
            for (int i = 0; i < N; i++) begin
                en[i]   = ($urandom_range(15, 0) != 0);
                ctrl[i] = ($urandom_range(99, 0) < p);
                crc[i]  = ($urandom_range(99, 0) < p);
            end
            drive(en, ctrl, crc, ($urandom_range(63, 0) == 0));
            if ($urandom_range(699, 0) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
